// File: rtl/game_pkg.sv
// Shared status encoding and controller state type for the game-flow FSM and video path.
package game_pkg;

   localparam logic [2:0] STATUS_PLAYING   = 3'd0;
   localparam logic [2:0] STATUS_LEVEL_WIN = 3'd1;
   localparam logic [2:0] STATUS_WORLD_WIN = 3'd2;
   localparam logic [2:0] STATUS_GAME_WIN  = 3'd3;
   localparam logic [2:0] STATUS_GAME_OVER = 3'd4;
   localparam logic [2:0] STATUS_LIFE_LOST = 3'd5;
   localparam logic [2:0] STATUS_PAUSED    = 3'd6;
   localparam logic [2:0] STATUS_IDLE      = 3'd7;

   // State encoding equals the status code so the state register drives status directly.
   typedef enum logic [2:0] {
      S_PLAYING   = STATUS_PLAYING,
      S_LEVEL_WIN = STATUS_LEVEL_WIN,
      S_WORLD_WIN = STATUS_WORLD_WIN,
      S_GAME_WIN  = STATUS_GAME_WIN,
      S_GAME_OVER = STATUS_GAME_OVER,
      S_LIFE_LOST = STATUS_LIFE_LOST,
      S_PAUSED    = STATUS_PAUSED,
      S_IDLE      = STATUS_IDLE
   } game_state_e;

   function automatic logic is_banner(input game_state_e s);
      return (s == S_LEVEL_WIN) || (s == S_WORLD_WIN) || (s == S_LIFE_LOST);
   endfunction

endpackage

// File: rtl/game_tick_gen.sv
// Divides clk down to a one-cycle tick; restartable so each state gets whole ticks.
module game_tick_gen #(
   parameter int unsigned TICK_DIV = 100_000_000
) (
   input  logic clk,
   input  logic rst,
   input  logic clear,
   input  logic run,
   output logic tick
);

   localparam int unsigned CW = $clog2(TICK_DIV);

   logic [CW-1:0] count;

   assign tick = run && (count == CW'(TICK_DIV - 1));

   always_ff @(posedge clk or negedge rst) begin
      if (!rst)       count <= '0;
      else if (clear) count <= '0;
      else if (run)   count <= tick ? '0 : count + CW'(1);
   end

endmodule

// File: rtl/game_flow_ctrl.sv
// Game progress controller: level/world sequencing, lives, per-level countdown,
// pause and timed win/lose banners.
module game_flow_ctrl
   import game_pkg::*;
#(
   parameter int unsigned LEVELS_PER_WORLD = 4,
   parameter int unsigned WORLDS           = 2,
   parameter int unsigned LIVES            = 3,
   parameter int unsigned LEVEL_TIME       = 60,
   parameter int unsigned TICK_DIV         = 100_000_000,
   parameter int unsigned BANNER_TICKS     = 2,
   localparam int unsigned LW = (LEVELS_PER_WORLD > 1) ? $clog2(LEVELS_PER_WORLD) : 1,
   localparam int unsigned WW = (WORLDS > 1) ? $clog2(WORLDS) : 1,
   localparam int unsigned TW = $clog2(LEVEL_TIME + 1)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          start,
   input  logic          level_passed,
   input  logic          lose,
   input  logic          pause,
   output logic [LW-1:0] level,
   output logic [WW-1:0] world,
   output logic [3:0]    lives,
   output logic [TW-1:0] time_left,
   output logic [2:0]    status,
   output logic          play_en,
   output logic          level_load
);

   localparam int unsigned BW = $clog2(BANNER_TICKS + 1);

   game_state_e   state, state_d;
   logic [LW-1:0] level_d;
   logic [WW-1:0] world_d;
   logic [3:0]    lives_d;
   logic [TW-1:0] time_d;
   logic [BW-1:0] bcnt, bcnt_d;
   logic          play_d, load_d;
   logic          tick, state_chg, run;

   assign state_chg = (state_d != state);
   assign run       = (state == S_PLAYING) || is_banner(state);
   assign status    = state;

   game_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
      .clk   (clk),
      .rst   (rst),
      .clear (state_chg),
      .run   (run),
      .tick  (tick)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state      <= S_IDLE;
         level      <= '0;
         world      <= '0;
         lives      <= 4'(LIVES);
         time_left  <= TW'(LEVEL_TIME);
         bcnt       <= '0;
         play_en    <= 1'b0;
         level_load <= 1'b0;
      end else begin
         state      <= state_d;
         level      <= level_d;
         world      <= world_d;
         lives      <= lives_d;
         time_left  <= time_d;
         bcnt       <= bcnt_d;
         play_en    <= play_d;
         level_load <= load_d;
      end
   end

   always_comb begin
      state_d = state;
      level_d = level;
      world_d = world;
      lives_d = lives;
      time_d  = time_left;
      bcnt_d  = bcnt;
      case (state)
         S_IDLE, S_GAME_WIN, S_GAME_OVER: begin
            if (start) begin
               state_d = S_PLAYING;
               level_d = '0;
               world_d = '0;
               lives_d = 4'(LIVES);
               time_d  = TW'(LEVEL_TIME);
            end
         end
         S_PLAYING: begin
            if (tick && (time_left != '0)) time_d = time_left - TW'(1);
            // Priority: level_passed, then lose/timeout, then pause.
            if (level_passed) begin
               if (level != LW'(LEVELS_PER_WORLD - 1)) state_d = S_LEVEL_WIN;
               else if (world != WW'(WORLDS - 1))      state_d = S_WORLD_WIN;
               else                                    state_d = S_GAME_WIN;
            end else if (lose || (tick && (time_left <= TW'(1)))) begin
               if (lives != 4'd0) lives_d = lives - 4'd1;
               state_d = (lives <= 4'd1) ? S_GAME_OVER : S_LIFE_LOST;
            end else if (pause) begin
               state_d = S_PAUSED;
            end
         end
         S_PAUSED: begin
            if (pause) state_d = S_PLAYING;
         end
         S_LEVEL_WIN, S_WORLD_WIN, S_LIFE_LOST: begin
            if (tick) begin
               if (bcnt == BW'(BANNER_TICKS - 1)) begin
                  state_d = S_PLAYING;
                  time_d  = TW'(LEVEL_TIME);
                  if (state == S_LEVEL_WIN) level_d = level + LW'(1);
                  if (state == S_WORLD_WIN) begin
                     level_d = '0;
                     world_d = world + WW'(1);
                  end
               end else begin
                  bcnt_d = bcnt + BW'(1);
               end
            end
         end
      endcase
      if (state_chg) bcnt_d = '0;
      play_d = (state_d == S_PLAYING);
      load_d = (state_d == S_PLAYING) && (state != S_PLAYING) && (state != S_PAUSED);
   end

endmodule

// File: tb/tb_game_flow_ctrl.sv
// Directed bench for game_flow_ctrl with small parameters (2 levels, 2 worlds, 2 lives, 3 s, 4-cycle tick).
module tb_game_flow_ctrl;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       start = 1'b0;
   logic       level_passed = 1'b0;
   logic       lose = 1'b0;
   logic       pause = 1'b0;
   logic       level;
   logic       world;
   logic [3:0] lives;
   logic [1:0] time_left;
   logic [2:0] status;
   logic       play_en;
   logic       level_load;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   game_flow_ctrl #(
      .LEVELS_PER_WORLD (2),
      .WORLDS           (2),
      .LIVES            (2),
      .LEVEL_TIME       (3),
      .TICK_DIV         (4),
      .BANNER_TICKS     (1)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .start        (start),
      .level_passed (level_passed),
      .lose         (lose),
      .pause        (pause),
      .level        (level),
      .world        (world),
      .lives        (lives),
      .time_left    (time_left),
      .status       (status),
      .play_en      (play_en),
      .level_load   (level_load)
   );

   task automatic cyc(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Drive a one-cycle input pulse; returns just after the sampling edge.
   task automatic pulse(input bit s, input bit p, input bit l, input bit z);
      @(negedge clk);
      start = s; level_passed = p; lose = l; pause = z;
      @(posedge clk);
      #1;
      start = 1'b0; level_passed = 1'b0; lose = 1'b0; pause = 1'b0;
   endtask

   task automatic do_reset;
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      rst = 1'b1;
   endtask

   task automatic test_reset;
      #1 rst = 1'b0;
      #1;
      checks++;
      if ({status, level, world, lives, time_left, play_en, level_load} !== {3'd7, 1'b0, 1'b0, 4'd2, 2'd3, 1'b0, 1'b0}) begin
         errors++;
         $display("FAIL reset_values got st=%0d lv=%0d w=%0d li=%0d t=%0d pe=%0d ld=%0d exp 7 0 0 2 3 0 0",
                  status, level, world, lives, time_left, play_en, level_load);
      end
      @(negedge clk);
      rst = 1'b1;
      pulse(0, 1, 0, 0);
      pulse(0, 0, 1, 0);
      pulse(0, 0, 0, 1);
      cyc(3);
      checks++;
      if ({status, lives} !== {3'd7, 4'd2}) begin
         errors++;
         $display("FAIL idle_ignores got st=%0d li=%0d exp 7 2", status, lives);
      end
   endtask

   task automatic test_start;
      pulse(1, 0, 0, 0);
      checks++;
      if ({status, level_load, play_en, time_left, lives} !== {3'd0, 1'b1, 1'b1, 2'd3, 4'd2}) begin
         errors++;
         $display("FAIL start_entry got st=%0d ld=%0d pe=%0d t=%0d li=%0d exp 0 1 1 3 2",
                  status, level_load, play_en, time_left, lives);
      end
      cyc(1);
      checks++;
      if (level_load !== 1'b0) begin
         errors++;
         $display("FAIL start_load_width got %0d exp 0", level_load);
      end
   endtask

   task automatic test_countdown;
      do_reset();
      pulse(1, 0, 0, 0);
      cyc(3);
      checks++;
      if (time_left !== 2'd3) begin
         errors++;
         $display("FAIL cd_before_tick got %0d exp 3", time_left);
      end
      cyc(1);
      checks++;
      if (time_left !== 2'd2) begin
         errors++;
         $display("FAIL cd_tick1 got %0d exp 2", time_left);
      end
      cyc(4);
      checks++;
      if (time_left !== 2'd1) begin
         errors++;
         $display("FAIL cd_tick2 got %0d exp 1", time_left);
      end
      cyc(4);
      checks++;
      if ({status, lives, time_left, play_en} !== {3'd5, 4'd1, 2'd0, 1'b0}) begin
         errors++;
         $display("FAIL cd_timeout got st=%0d li=%0d t=%0d pe=%0d exp 5 1 0 0", status, lives, time_left, play_en);
      end
      cyc(4);
      checks++;
      if ({status, time_left, level_load} !== {3'd0, 2'd3, 1'b1}) begin
         errors++;
         $display("FAIL cd_banner_exit got st=%0d t=%0d ld=%0d exp 0 3 1", status, time_left, level_load);
      end
      cyc(1);
      checks++;
      if (level_load !== 1'b0) begin
         errors++;
         $display("FAIL cd_load_width got %0d exp 0", level_load);
      end
   endtask

   task automatic test_level_seq;
      logic [2:0] exp_st [4] = '{3'd1, 3'd2, 3'd1, 3'd3};
      logic [1:0] exp_wl [3] = '{2'b01, 2'b10, 2'b11};
      do_reset();
      pulse(1, 0, 0, 0);
      for (int i = 0; i < 4; i++) begin
         pulse(0, 1, 0, 0);
         checks++;
         if (status !== exp_st[i]) begin
            errors++;
            $display("FAIL seq_status%0d got %0d exp %0d", i, status, exp_st[i]);
         end
         if (i < 3) begin
            cyc(4);
            checks++;
            if ({status, world, level, level_load} !== {3'd0, exp_wl[i], 1'b1}) begin
               errors++;
               $display("FAIL seq_exit%0d got st=%0d w=%0d lv=%0d ld=%0d exp 0 %0d %0d 1",
                        i, status, world, level, level_load, exp_wl[i][1], exp_wl[i][0]);
            end
         end
      end
      cyc(20);
      checks++;
      if (status !== 3'd3) begin
         errors++;
         $display("FAIL seq_game_win_hold got %0d exp 3", status);
      end
   endtask

   task automatic test_lose;
      do_reset();
      pulse(1, 0, 0, 0);
      pulse(0, 1, 0, 0);
      cyc(4);
      pulse(0, 0, 1, 0);
      checks++;
      if ({status, lives} !== {3'd5, 4'd1}) begin
         errors++;
         $display("FAIL lose1 got st=%0d li=%0d exp 5 1", status, lives);
      end
      cyc(4);
      checks++;
      if ({status, level, level_load} !== {3'd0, 1'b1, 1'b1}) begin
         errors++;
         $display("FAIL lose1_same_level got st=%0d lv=%0d ld=%0d exp 0 1 1", status, level, level_load);
      end
      pulse(0, 0, 1, 0);
      checks++;
      if ({status, lives} !== {3'd4, 4'd0}) begin
         errors++;
         $display("FAIL lose2_game_over got st=%0d li=%0d exp 4 0", status, lives);
      end
      cyc(10);
      checks++;
      if (status !== 3'd4) begin
         errors++;
         $display("FAIL game_over_hold got %0d exp 4", status);
      end
      pulse(1, 0, 0, 0);
      checks++;
      if ({status, lives, level, world, time_left, level_load} !== {3'd0, 4'd2, 1'b0, 1'b0, 2'd3, 1'b1}) begin
         errors++;
         $display("FAIL restart got st=%0d li=%0d lv=%0d w=%0d t=%0d ld=%0d exp 0 2 0 0 3 1",
                  status, lives, level, world, time_left, level_load);
      end
   endtask

   task automatic test_pause;
      do_reset();
      pulse(1, 0, 0, 0);
      cyc(4);
      pulse(0, 0, 0, 1);
      checks++;
      if ({status, time_left, play_en} !== {3'd6, 2'd2, 1'b0}) begin
         errors++;
         $display("FAIL pause_enter got st=%0d t=%0d pe=%0d exp 6 2 0", status, time_left, play_en);
      end
      cyc(8);
      pulse(0, 1, 1, 0);
      cyc(10);
      checks++;
      if ({status, time_left, lives, level} !== {3'd6, 2'd2, 4'd2, 1'b0}) begin
         errors++;
         $display("FAIL pause_frozen got st=%0d t=%0d li=%0d lv=%0d exp 6 2 2 0", status, time_left, lives, level);
      end
      pulse(0, 0, 0, 1);
      checks++;
      if ({status, level_load, play_en, time_left} !== {3'd0, 1'b0, 1'b1, 2'd2}) begin
         errors++;
         $display("FAIL pause_resume got st=%0d ld=%0d pe=%0d t=%0d exp 0 0 1 2", status, level_load, play_en, time_left);
      end
   endtask

   task automatic test_simultaneous;
      do_reset();
      pulse(1, 0, 0, 0);
      pulse(0, 1, 1, 0);
      checks++;
      if ({status, lives} !== {3'd1, 4'd2}) begin
         errors++;
         $display("FAIL pass_beats_lose got st=%0d li=%0d exp 1 2", status, lives);
      end
      cyc(2);
      @(negedge clk);
      rst = 1'b0;
      #1;
      checks++;
      if ({status, level, world, lives, time_left, play_en, level_load} !== {3'd7, 1'b0, 1'b0, 4'd2, 2'd3, 1'b0, 1'b0}) begin
         errors++;
         $display("FAIL async_reset_mid_banner got st=%0d lv=%0d w=%0d li=%0d t=%0d pe=%0d ld=%0d exp 7 0 0 2 3 0 0",
                  status, level, world, lives, time_left, play_en, level_load);
      end
      @(negedge clk);
      rst = 1'b1;
      pulse(1, 0, 0, 0);
      pulse(0, 0, 1, 1);
      checks++;
      if ({status, lives} !== {3'd5, 4'd1}) begin
         errors++;
         $display("FAIL lose_beats_pause got st=%0d li=%0d exp 5 1", status, lives);
      end
   endtask

   initial begin
      test_reset();
      test_start();
      test_countdown();
      test_level_seq();
      test_lose();
      test_pause();
      test_simultaneous();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/game_flow_ctrl.md
# game_flow_ctrl

Parametrised game-progress controller that replaces the fixed level/world FSM in the `Game` top level. It sequences levels and worlds, tracks lives and a per-level countdown, and supports pause. It also holds the win/lose banner states for a fixed time. It drives `status`, `level`, `world`, `lives` and `time_left` to the video path, and `play_en` and `level_load` to the player and obstacle objects.

## Interface
Parameters:
- `LEVELS_PER_WORLD`, 4: levels in each world (≥1).
- `WORLDS`, 2: number of worlds (≥1).
- `LIVES`, 3: lives at game start (1..15).
- `LEVEL_TIME`, 60: countdown seconds per level (≥1).
- `TICK_DIV`, 100_000_000: `clk` cycles per second tick (≥2).
- `BANNER_TICKS`, 2: seconds that each banner state is held (≥1).

Ports:
- `clk` in 1: system clock.
- `rst` in 1: reset, asynchronous, active-low.
- `start` in 1: single-cycle pulse that begins or restarts the game.
- `level_passed` in 1: single-cycle pulse, player cleared the level.
- `lose` in 1: single-cycle pulse, player hit a hazard.
- `pause` in 1: single-cycle pulse that toggles pause.
- `level` out max(1,$clog2(LEVELS_PER_WORLD)): current level within the world.
- `world` out max(1,$clog2(WORLDS)): current world.
- `lives` out 4: remaining lives.
- `time_left` out $clog2(LEVEL_TIME+1): seconds remaining.
- `status` out 3: encoded state (see Operation).
- `play_en` out 1: high only in PLAYING.
- `level_load` out 1: one-cycle pulse that (re)initialises the objects.

## Operation
- Status codes: PLAYING=0, LEVEL_WIN=1, WORLD_WIN=2, GAME_WIN=3, GAME_OVER=4, LIFE_LOST=5, PAUSED=6, IDLE=7. Codes 0–4 keep the legacy meanings.
- IDLE: `start` → PLAYING. level=0, world=0, lives=LIVES, time_left=LEVEL_TIME.
- PLAYING:
  - `level_passed` → LEVEL_WIN if not on the last level of the world.
  - `level_passed` → WORLD_WIN if on the last level and not in the last world.
  - `level_passed` → GAME_WIN if on the last level of the last world.
  - `lose`, or time_left reaching 0, → LIFE_LOST, with lives decremented. If lives becomes 0, the transition goes to GAME_OVER instead.
  - `pause` → PAUSED.
- Simultaneous events in PLAYING: `level_passed` has priority over `lose` and over timeout. `pause` is ignored when any other event is present.
- PAUSED: `pause` → PLAYING. The tick counter and time_left are frozen; `level_passed` and `lose` are ignored.
- Banner states hold for BANNER_TICKS ticks, then exit as follows:
  - LEVEL_WIN → PLAYING with level+1.
  - WORLD_WIN → PLAYING with level=0 and world+1.
  - LIFE_LOST → PLAYING with the same level.
  - Every banner exit reloads time_left to LEVEL_TIME.
- GAME_WIN and GAME_OVER are terminal. `start` re-enters PLAYING with the full IDLE initialisation.
- `start` in any other state is ignored.
- `level_load` pulses for exactly one cycle on every entry to PLAYING, except the PAUSED→PLAYING return.
- Inputs `level_passed` and `lose` are ignored outside PLAYING.

## Timing
- All outputs are registered.
- Reset values: status=IDLE(7), level=0, world=0, lives=LIVES, time_left=LEVEL_TIME, play_en=0, level_load=0. Asynchronous reset assertion forces these in any state, including mid-banner or mid-countdown.
- Event at input edge N: `status` changes at edge N+1. `level_load` is high during cycle N+1 to N+2.
- Tick counter:
  - Counts 0..TICK_DIV-1 and issues `tick` when count==TICK_DIV-1.
  - Clears to 0 on every state change, so each state gets full ticks.
  - Counts only in PLAYING and in the banner states.
- time_left decrements on each tick in PLAYING and saturates at 0. The tick that makes it 0 causes LIFE_LOST (or GAME_OVER) on the same edge as the decrement.
- Banner exit occurs on the edge of the BANNER_TICKS-th tick.

## Structure
- Package `game_pkg`: status code localparams and the state enum, shared with the video path.
- Sub-module `game_tick_gen` (params TICK_DIV): inputs `clear` and `run`, output a one-cycle `tick`.
- The remaining logic is one FSM with counters for level, world, lives, time and banner.

## Test plan
Parameters for all scenarios: LEVELS_PER_WORLD=2, WORLDS=2, LIVES=2, LEVEL_TIME=3, TICK_DIV=4, BANNER_TICKS=1.
- Reset, then `start` → status 7 then 0; `level_load` high for 1 cycle; time_left=3; lives=2.
- With no further input → time_left goes 3,2,1 on ticks 4 cycles apart; on reaching 0 → status 5, lives=1; after 4 more cycles → status 0, time_left=3, `level_load` pulses.
- `level_passed` ×4, each after its banner → status sequence 1, 2, 1, 3; (world,level) sequence (0,1), (1,0), (1,1); final status 3 holds.
- `lose` twice → status 5 then 4; status stays 4; a later `start` → status 0 with lives=2, level=0, world=0.
- `pause` at time_left=2 → status 6; 20 cycles elapse with time_left still 2 and `lose` ignored; `pause` → status 0 and no `level_load` pulse.
- `level_passed` and `lose` in the same cycle → status 1 and lives unchanged. Separately, asserting `rst` mid-LEVEL_WIN → all outputs at reset values immediately.
